// File: rtl/reg_pw_shadow_if.sv
// Register-bus bundle for the PW-USB frontend register block on cwusb_clk.
// The host side drives address/data/strobes; the block returns read_data and selected.
interface reg_pw_shadow_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic [7:0]               read_data;
    logic                     selected;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  read_data, selected
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output read_data, selected
    );
endinterface

// File: rtl/reg_pw_shadow.sv
// Double-buffered trigger/pattern register block with arm FSM and deferred atomic commit.
// Optional STAT comparators and saturating match counters are built when REG_PW_STAT_SLOTS_EN is defined.
module reg_pw_shadow #(
    parameter int pBYTECNT_SIZE       = 7,
    parameter int pPATTERN_BYTES      = 8,
    parameter int pNUM_TRIGGER_PULSES = 8,
    parameter int pTRIG_FIELD_WIDTH   = 24,
    parameter int pNUM_TRIGGER_WIDTH  = 4,
    parameter int pNUM_STAT_SLOTS     = 4,
    parameter int pSTAT_WIDTH         = 5,
    parameter int pMATCH_COUNT_WIDTH  = 16
) (
    input  logic                                            cwusb_clk,
    input  logic                                            reset_n,
    reg_pw_shadow_if.slave                                  bus,
    input  logic                                            I_capture_enable_pulse,
    input  logic                                            I_capture_done,
    input  logic                                            I_flushing,
    input  logic [pSTAT_WIDTH-1:0]                          I_fe_capture_stat,
    input  logic                                            I_stat_valid,
    output logic                                            O_arm,
    output logic [8*pPATTERN_BYTES-1:0]                     O_pattern,
    output logic [8*pPATTERN_BYTES-1:0]                     O_pattern_mask,
    output logic [7:0]                                      O_pattern_bytes,
    output logic [pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES-1:0] O_trigger_delay,
    output logic [pTRIG_FIELD_WIDTH*pNUM_TRIGGER_PULSES-1:0] O_trigger_width,
    output logic [pNUM_TRIGGER_WIDTH-1:0]                   O_num_triggers,
    output logic                                            O_trigger_enable,
    output logic                                            O_commit_pulse
);
    localparam int PAT_BITS  = 8 * pPATTERN_BYTES;
    localparam int TRIG_BITS = pTRIG_FIELD_WIDTH * pNUM_TRIGGER_PULSES;
    localparam int MAXW      = PAT_BITS + TRIG_BITS + pNUM_TRIGGER_WIDTH + pMATCH_COUNT_WIDTH;

    localparam logic [5:0] A_ARM        = 6'h00;
    localparam logic [5:0] A_CTRL       = 6'h01;
    localparam logic [5:0] A_STATUS     = 6'h02;
    localparam logic [5:0] A_PATTERN    = 6'h03;
    localparam logic [5:0] A_PMASK      = 6'h04;
    localparam logic [5:0] A_PBYTES     = 6'h05;
    localparam logic [5:0] A_TEN        = 6'h06;
    localparam logic [5:0] A_NTRIG      = 6'h07;
    localparam logic [5:0] A_TDELAY     = 6'h08;
    localparam logic [5:0] A_TWIDTH     = 6'h09;
    localparam logic [5:0] A_STAT_SEL   = 6'h0A;
    localparam logic [5:0] A_STAT_COUNT = 6'h0B;
    localparam logic [5:0] A_STAT_CFG   = 6'h0C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PAT_BITS-1:0]           pattern;
        logic [PAT_BITS-1:0]           mask;
        logic [7:0]                    pattern_bytes;
        logic                          trig_en;
        logic [pNUM_TRIGGER_WIDTH-1:0] num_trig;
        logic [TRIG_BITS-1:0]          delay;
        logic [TRIG_BITS-1:0]          width;
    } cfg_t;

    localparam cfg_t CFG_RST = '{pattern: '0, mask: '0, pattern_bytes: '0, trig_en: 1'b0,
                                 num_trig: pNUM_TRIGGER_WIDTH'(1), delay: '0, width: '0};

    // Byte-addressed access into an n-bit field; bytes past the field are dropped / read as 0.
    function automatic logic [MAXW-1:0] put_byte(input logic [MAXW-1:0] v, input int n,
                                                 input int idx, input logic [7:0] d);
        logic [MAXW-1:0] r;
        r = v;
        for (int b = 0; b < MAXW; b++)
            if (b < n && (b >> 3) == idx) r[b] = d[b[2:0]];
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [MAXW-1:0] v, input int n, input int idx);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < MAXW; b++)
            if (b < n && (b >> 3) == idx) r[b[2:0]] = v[b];
        return r;
    endfunction

    logic [pBYTECNT_SIZE-1:0] bytecnt;
    int                       byte_idx;
    logic [5:0]               off;
    logic [7:0]               wd;
    logic                     wr_en, rd_en, byte0_wr;
    logic                     commit_req, discard, entering_idle, do_copy;

    state_t     state_q, state_d;
    logic       arm_q, arm_d;
    logic       commit_pulse_q, commit_pulse_d;
    logic       commit_pending_q, commit_pending_d;
    logic [7:0] read_data_q, read_data_d;
    logic [7:0] rdat;
    cfg_t       sh_q, sh_d, act_q, act_d;

    assign bus.selected = bus.reg_addrvalid && (bus.reg_address[7:6] == 2'b10);
    assign bus.read_data = read_data_q;
    assign bytecnt  = bus.reg_bytecnt;
    assign byte_idx = int'(bytecnt);
    assign off      = bus.reg_address[5:0];
    assign wd       = bus.write_data;
    assign wr_en    = bus.selected && bus.reg_write;
    assign rd_en    = bus.selected && bus.reg_read;
    assign byte0_wr = wr_en && (byte_idx == 0);

    assign commit_req = byte0_wr && (off == A_CTRL) && wd[0] && !wd[1];
    assign discard    = byte0_wr && (off == A_CTRL) && wd[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (byte0_wr && off == A_ARM && wd[0]) state_d = S_ARMED;
            S_ARMED: if (I_capture_enable_pulse) state_d = S_CAPT;
            S_CAPT:  if (I_capture_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (byte0_wr && off == A_ARM && !wd[0]) state_d = S_IDLE;
    end

    // A commit requested in the same cycle the FSM drops back to IDLE is applied immediately.
    assign entering_idle = (state_q != S_IDLE) && (state_d == S_IDLE);
    assign do_copy = !discard && ((commit_req && state_q == S_IDLE) ||
                                  ((commit_pending_q || commit_req) && entering_idle));

    always_comb begin
        commit_pending_d = commit_pending_q;
        if (discard || do_copy)
            commit_pending_d = 1'b0;
        else if (commit_req && state_q != S_IDLE)
            commit_pending_d = 1'b1;
        commit_pulse_d = do_copy;
        arm_d          = (state_q == S_ARMED) && !I_flushing;
    end

    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (discard) begin
            sh_d = act_q;
        end else if (wr_en) begin
            case (off)
                A_PATTERN: sh_d.pattern  = PAT_BITS'(put_byte(MAXW'(sh_q.pattern), PAT_BITS, byte_idx, wd));
                A_PMASK:   sh_d.mask     = PAT_BITS'(put_byte(MAXW'(sh_q.mask), PAT_BITS, byte_idx, wd));
                A_PBYTES:  if (byte_idx == 0) sh_d.pattern_bytes = wd;
                A_TEN:     if (byte_idx == 0) sh_d.trig_en = wd[0];
                A_NTRIG:   sh_d.num_trig = pNUM_TRIGGER_WIDTH'(put_byte(MAXW'(sh_q.num_trig),
                                                                        pNUM_TRIGGER_WIDTH, byte_idx, wd));
                A_TDELAY:  sh_d.delay    = TRIG_BITS'(put_byte(MAXW'(sh_q.delay), TRIG_BITS, byte_idx, wd));
                A_TWIDTH:  sh_d.width    = TRIG_BITS'(put_byte(MAXW'(sh_q.width), TRIG_BITS, byte_idx, wd));
                default: ;
            endcase
        end
        if (do_copy) act_d = sh_q;
    end

`ifdef REG_PW_STAT_SLOTS_EN
    localparam int SELW = (pNUM_STAT_SLOTS > 1) ? $clog2(pNUM_STAT_SLOTS) : 1;

    logic [SELW-1:0]               stat_sel_q, stat_sel_d;
    logic [pSTAT_WIDTH-1:0]        slot_pat_q [pNUM_STAT_SLOTS];
    logic [pSTAT_WIDTH-1:0]        slot_pat_d [pNUM_STAT_SLOTS];
    logic [pSTAT_WIDTH-1:0]        slot_mask_q [pNUM_STAT_SLOTS];
    logic [pSTAT_WIDTH-1:0]        slot_mask_d [pNUM_STAT_SLOTS];
    logic [pMATCH_COUNT_WIDTH-1:0] cnt_q [pNUM_STAT_SLOTS];
    logic [pMATCH_COUNT_WIDTH-1:0] cnt_d [pNUM_STAT_SLOTS];
    logic [pNUM_STAT_SLOTS-1:0]    slot_match;
    logic                          arm_start;

    assign arm_start = (state_q == S_IDLE) && (state_d == S_ARMED);

    for (genvar gi = 0; gi < pNUM_STAT_SLOTS; gi++) begin : g_slot
        assign slot_match[gi] = I_stat_valid &&
            ((I_fe_capture_stat & slot_mask_q[gi]) == (slot_pat_q[gi] & slot_mask_q[gi]));
    end

    always_comb begin
        stat_sel_d = stat_sel_q;
        if (byte0_wr && off == A_STAT_SEL) stat_sel_d = wd[SELW-1:0];
        for (int k = 0; k < pNUM_STAT_SLOTS; k++) begin
            slot_pat_d[k]  = slot_pat_q[k];
            slot_mask_d[k] = slot_mask_q[k];
            if (wr_en && off == A_STAT_CFG && stat_sel_q == SELW'(k)) begin
                if (byte_idx == 0) slot_pat_d[k]  = wd[pSTAT_WIDTH-1:0];
                if (byte_idx == 1) slot_mask_d[k] = wd[pSTAT_WIDTH-1:0];
            end
            // Re-arming wins over a simultaneous match.
            if (arm_start)
                cnt_d[k] = '0;
            else if (slot_match[k] && cnt_q[k] != '1)
                cnt_d[k] = cnt_q[k] + pMATCH_COUNT_WIDTH'(1);
            else
                cnt_d[k] = cnt_q[k];
        end
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_sel_q <= '0;
            for (int k = 0; k < pNUM_STAT_SLOTS; k++) begin
                slot_pat_q[k]  <= '0;
                slot_mask_q[k] <= '1;
                cnt_q[k]       <= '0;
            end
        end else begin
            stat_sel_q <= stat_sel_d;
            for (int k = 0; k < pNUM_STAT_SLOTS; k++) begin
                slot_pat_q[k]  <= slot_pat_d[k];
                slot_mask_q[k] <= slot_mask_d[k];
                cnt_q[k]       <= cnt_d[k];
            end
        end
    end
`else
    localparam int unused_slot_cfg = pNUM_STAT_SLOTS;
    logic unused_stat_inputs;
    assign unused_stat_inputs = ^{I_fe_capture_stat, I_stat_valid};
`endif

    always_comb begin
        rdat = 8'h00;
        case (off)
            A_ARM:     if (byte_idx == 0) rdat[0] = (state_q != S_IDLE);
            A_STATUS:  if (byte_idx == 0) rdat = {5'b0, commit_pending_q, state_q};
            A_PATTERN: rdat = get_byte(MAXW'(sh_q.pattern), PAT_BITS, byte_idx);
            A_PMASK:   rdat = get_byte(MAXW'(sh_q.mask), PAT_BITS, byte_idx);
            A_PBYTES:  if (byte_idx == 0) rdat = sh_q.pattern_bytes;
            A_TEN:     if (byte_idx == 0) rdat[0] = sh_q.trig_en;
            A_NTRIG:   rdat = get_byte(MAXW'(sh_q.num_trig), pNUM_TRIGGER_WIDTH, byte_idx);
            A_TDELAY:  rdat = get_byte(MAXW'(sh_q.delay), TRIG_BITS, byte_idx);
            A_TWIDTH:  rdat = get_byte(MAXW'(sh_q.width), TRIG_BITS, byte_idx);
`ifdef REG_PW_STAT_SLOTS_EN
            A_STAT_SEL:   if (byte_idx == 0) rdat[SELW-1:0] = stat_sel_q;
            A_STAT_COUNT: rdat = get_byte(MAXW'(cnt_q[stat_sel_q]), pMATCH_COUNT_WIDTH, byte_idx);
            A_STAT_CFG: begin
                if (byte_idx == 0) rdat[pSTAT_WIDTH-1:0] = slot_pat_q[stat_sel_q];
                if (byte_idx == 1) rdat[pSTAT_WIDTH-1:0] = slot_mask_q[stat_sel_q];
            end
`endif
            default: ;
        endcase
        read_data_d = rd_en ? rdat : 8'h00;
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            arm_q            <= 1'b0;
            commit_pulse_q   <= 1'b0;
            commit_pending_q <= 1'b0;
            read_data_q      <= 8'h00;
            sh_q             <= CFG_RST;
            act_q            <= CFG_RST;
        end else begin
            state_q          <= state_d;
            arm_q            <= arm_d;
            commit_pulse_q   <= commit_pulse_d;
            commit_pending_q <= commit_pending_d;
            read_data_q      <= read_data_d;
            sh_q             <= sh_d;
            act_q            <= act_d;
        end
    end

    assign O_arm            = arm_q;
    assign O_commit_pulse   = commit_pulse_q;
    assign O_pattern        = act_q.pattern;
    assign O_pattern_mask   = act_q.mask;
    assign O_pattern_bytes  = act_q.pattern_bytes;
    assign O_trigger_enable = act_q.trig_en;
    assign O_num_triggers   = act_q.num_trig;
    assign O_trigger_delay  = act_q.delay;
    assign O_trigger_width  = act_q.width;
endmodule

// File: tb/tb_reg_pw_shadow.sv
// Directed bench for reg_pw_shadow: shadow/active commit, arm FSM, discard, STAT counters, async reset.
module tb_reg_pw_shadow;
    localparam logic [5:0] A_ARM = 6'h00, A_CTRL = 6'h01, A_STATUS = 6'h02, A_PATTERN = 6'h03;
    localparam logic [5:0] A_PMASK = 6'h04, A_NTRIG = 6'h07, A_TDELAY = 6'h08, A_TWIDTH = 6'h09;
    localparam logic [5:0] A_SSEL = 6'h0A, A_SCNT = 6'h0B, A_SCFG = 6'h0C;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cap_en = 1'b0, cap_done = 1'b0, flushing = 1'b0;
    logic [4:0]   stat = 5'd0;
    logic         stat_valid = 1'b0;
    logic         o_arm, o_pulse, o_ten;
    logic [63:0]  o_pattern, o_pmask;
    logic [7:0]   o_pbytes;
    logic [191:0] o_delay, o_width;
    logic [3:0]   o_ntrig;

    int n_chk = 0;
    int n_pass = 0;
    int pulse_cnt = 0;
    int pc;

    always #5 clk = ~clk;

    reg_pw_shadow_if #(.pBYTECNT_SIZE(7)) bus ();

    reg_pw_shadow dut (
        .cwusb_clk(clk), .reset_n(reset_n), .bus(bus),
        .I_capture_enable_pulse(cap_en), .I_capture_done(cap_done), .I_flushing(flushing),
        .I_fe_capture_stat(stat), .I_stat_valid(stat_valid),
        .O_arm(o_arm), .O_pattern(o_pattern), .O_pattern_mask(o_pmask), .O_pattern_bytes(o_pbytes),
        .O_trigger_delay(o_delay), .O_trigger_width(o_width), .O_num_triggers(o_ntrig),
        .O_trigger_enable(o_ten), .O_commit_pulse(o_pulse)
    );

    always @(negedge clk) if (o_pulse === 1'b1) pulse_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [5:0] off, input logic [6:0] bc, input logic [7:0] d);
        bus.reg_address = {2'b10, off}; bus.reg_bytecnt = bc; bus.write_data = d;
        bus.reg_addrvalid = 1'b1; bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        $display("write off=0x%02h byte=%0d data=0x%02h", off, bc, d);
    endtask

    task automatic rdchk(input string tag, input logic [5:0] off, input logic [6:0] bc, input logic [7:0] exp);
        logic [7:0] d;
        bus.reg_address = {2'b10, off}; bus.reg_bytecnt = bc;
        bus.reg_addrvalid = 1'b1; bus.reg_read = 1'b1;
        tick();
        d = bus.read_data;
        bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
        $display("read  off=0x%02h byte=%0d data=0x%02h", off, bc, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    initial begin
        bus.reg_address = 8'h00; bus.reg_bytecnt = 7'd0; bus.write_data = 8'h00;
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        repeat (2) tick();
        chk("rst_arm", 64'(o_arm), 64'd0);
        chk("rst_pulse", 64'(o_pulse), 64'd0);
        chk("rst_ntrig", 64'(o_ntrig), 64'd1);
        chk("rst_pattern", o_pattern, 64'd0);
        chk("rst_rdata", 64'(bus.read_data), 64'd0);
        reset_n = 1'b1;
        tick();
        rdchk("rst_status", A_STATUS, 0, 8'h00);
        rdchk("rst_sh_ntrig", A_NTRIG, 0, 8'h01);

        // Shadow write, readback, commit in IDLE
        wr(A_PATTERN, 0, 8'hA5);
        rdchk("pat_readback", A_PATTERN, 0, 8'hA5);
        chk("pat_active_before", o_pattern[7:0], 64'h00);
        wr(A_PATTERN, 8, 8'hFF);
        rdchk("pat_beyond", A_PATTERN, 8, 8'h00);
        rdchk("unmapped", 6'h0F, 0, 8'h00);
        wr(A_NTRIG, 0, 8'h03);
        pc = pulse_cnt;
        wr(A_CTRL, 0, 8'h01);
        chk("pat_active_after", o_pattern[7:0], 64'hA5);
        chk("ntrig_active_after", 64'(o_ntrig), 64'd3);
        chk("pulse_high", 64'(o_pulse), 64'd1);
        tick();
        chk("pulse_low", 64'(o_pulse), 64'd0);
        chk("pulse_count_1", 64'(pulse_cnt - pc), 64'd1);
        chk("rdata_idle", 64'(bus.read_data), 64'd0);

        // Arm, flushing gate, capture, deferred commit
        wr(A_ARM, 0, 8'h01);
        rdchk("arm_read", A_ARM, 0, 8'h01);
        chk("o_arm_armed", 64'(o_arm), 64'd1);
        flushing = 1'b1; tick();
        chk("o_arm_flushing", 64'(o_arm), 64'd0);
        flushing = 1'b0; tick();
        chk("o_arm_unflushed", 64'(o_arm), 64'd1);
        cap_en = 1'b1; tick(); cap_en = 1'b0;
        rdchk("status_capt", A_STATUS, 0, 8'h02);
        wr(A_TDELAY, 0, 8'h10);
        wr(A_CTRL, 0, 8'h01);
        rdchk("status_pending", A_STATUS, 0, 8'h06);
        chk("delay_held", o_delay[23:0], 64'h0);
        pc = pulse_cnt;
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        chk("delay_committed", o_delay[23:0], 64'h10);
        chk("pulse_on_idle", 64'(o_pulse), 64'd1);
        tick();
        chk("pulse_count_2", 64'(pulse_cnt - pc), 64'd1);
        rdchk("status_after_done", A_STATUS, 0, 8'h00);

        // Pending commit discarded while ARMED
        wr(A_ARM, 0, 8'h01);
        wr(A_PMASK, 0, 8'h3C);
        wr(A_CTRL, 0, 8'h01);
        rdchk("status_armed_pend", A_STATUS, 0, 8'h05);
        pc = pulse_cnt;
        wr(A_CTRL, 0, 8'h03);
        rdchk("status_discard", A_STATUS, 0, 8'h01);
        rdchk("pmask_reverted", A_PMASK, 0, 8'h00);
        wr(A_ARM, 0, 8'h00);
        tick();
        rdchk("status_disarm", A_STATUS, 0, 8'h00);
        chk("no_pulse_discard", 64'(pulse_cnt - pc), 64'd0);
        chk("pmask_active", o_pmask, 64'd0);

        // Last byte of the trigger width vector and the byte just past it
        wr(A_TWIDTH, 23, 8'h7E);
        rdchk("twidth_b23", A_TWIDTH, 23, 8'h7E);
        wr(A_TWIDTH, 24, 8'h11);
        rdchk("twidth_b24", A_TWIDTH, 24, 8'h00);
        wr(A_CTRL, 0, 8'h01);
        chk("twidth_active", 64'(o_width[191:184]), 64'h7E);
        chk("delay_kept", o_delay[23:0], 64'h10);

`ifdef REG_PW_STAT_SLOTS_EN
        wr(A_SSEL, 0, 8'h05);
        rdchk("ssel_trunc", A_SSEL, 0, 8'h01);
        wr(A_SCFG, 0, 8'h05);
        wr(A_SCFG, 1, 8'h1F);
        rdchk("slot1_pat", A_SCFG, 0, 8'h05);
        wr(A_SSEL, 0, 8'h00);
        rdchk("slot0_mask_rst", A_SCFG, 1, 8'h1F);
        rdchk("slot0_pat_rst", A_SCFG, 0, 8'h00);
        wr(A_SSEL, 0, 8'h01);
        wr(A_ARM, 0, 8'h01);
        stat = 5'h05; stat_valid = 1'b1;
        repeat (3) tick();
        stat = 5'h04; tick();
        stat = 5'h05; stat_valid = 1'b0; tick();
        stat = 5'h00; stat_valid = 1'b1; tick();
        stat_valid = 1'b0;
        rdchk("slot1_count3", A_SCNT, 0, 8'h03);
        wr(A_SSEL, 0, 8'h00);
        rdchk("slot0_count1", A_SCNT, 0, 8'h01);
        wr(A_SSEL, 0, 8'h01);
        stat = 5'h05; stat_valid = 1'b1;
        repeat (65600) @(posedge clk);
        #1 stat_valid = 1'b0;
        rdchk("sat_lo", A_SCNT, 0, 8'hFF);
        rdchk("sat_hi", A_SCNT, 1, 8'hFF);
        rdchk("cnt_beyond", A_SCNT, 2, 8'h00);
        wr(A_ARM, 0, 8'h00);
        wr(A_ARM, 0, 8'h01);
        rdchk("cnt_cleared", A_SCNT, 0, 8'h00);
        rdchk("cnt_cleared_hi", A_SCNT, 1, 8'h00);
`else
        wr(A_SSEL, 0, 8'h01);
        rdchk("ssel_absent", A_SSEL, 0, 8'h00);
        wr(A_SCFG, 1, 8'h1F);
        rdchk("scfg_absent", A_SCFG, 1, 8'h00);
        rdchk("scnt_absent", A_SCNT, 0, 8'h00);
        wr(A_ARM, 0, 8'h01);
`endif

        // Asynchronous reset while CAPTURING with a commit pending
        cap_en = 1'b1; tick(); cap_en = 1'b0;
        wr(A_PATTERN, 1, 8'h77);
        wr(A_CTRL, 0, 8'h01);
        rdchk("status_pre_reset", A_STATUS, 0, 8'h06);
        #3 reset_n = 1'b0;
        #1;
        chk("async_pattern", o_pattern, 64'd0);
        chk("async_ntrig", 64'(o_ntrig), 64'd1);
        chk("async_delay", o_delay[63:0], 64'd0);
        chk("async_pulse", 64'(o_pulse), 64'd0);
        chk("async_arm", 64'(o_arm), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        rdchk("post_rst_arm", A_ARM, 0, 8'h00);
        rdchk("post_rst_status", A_STATUS, 0, 8'h00);
        rdchk("post_rst_pat1", A_PATTERN, 1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
